axi4_burst_sched: RTL and testbench
===================================

AXI4_BURST_SCHED -- requirements
Module: axi4_burst_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be clk and the reset port srst.
REQ-002 Parameter ADDR_WIDTH, 32, AXI address width.
REQ-003 Parameter DATA_WIDTH, 32, AXI data width in bits.
REQ-004 Parameter BURST_LEN, 8, beats per burst; BURST_BYTES = BURST_LEN*DATA_WIDTH/8.
REQ-005 Parameter BASE_ADDR, 32'h00000000, start of circular buffer region.
REQ-006 Parameter NUM_SLOTS, 16, burst-sized slots in region (>=2).
REQ-007 Parameter TIMEOUT_CYC, 1024, max WAIT cycles per transaction.
REQ-008 clk  in  1  clock.
REQ-009 srst  in  1  synchronous active-high reset.
REQ-010 enable  in  1  scheduling permitted.
REQ-011 clear_err  in  1  one-cycle pulse, leaves ERROR.
REQ-012 wr_src_prog_empty  in  1  source FIFO holds less than one burst.
REQ-013 rd_dst_prog_full  in  1  destination FIFO cannot accept one burst.
REQ-014 txn_start  out  1  one-cycle pulse, starts AXI burst (drives controller init_axi_txn).
REQ-015 txn_write  out  1  1 = write burst, 0 = read burst.
REQ-016 txn_addr  out  ADDR_WIDTH  burst start address.
REQ-017 txn_done  in  1  controller completion pulse.
REQ-018 txn_error  in  1  controller error, sampled with txn_done.
REQ-019 occupancy  out  $clog2(NUM_SLOTS+1)  filled slots.
REQ-020 busy  out  1  state not IDLE.
REQ-021 err_sticky  out  1  response error latched.
REQ-022 timeout  out  1  timeout latched.

Function
REQ-023 FSM states SHALL be IDLE, ARB, ISSUE, WAIT, UPDATE, ERROR.
REQ-024 IDLE->ARB when enable=1; ARB->IDLE when enable=0; enable deassert in ISSUE/WAIT/UPDATE SHALL NOT abort the in-flight burst.
REQ-025 Write eligible = !wr_src_prog_empty && occupancy<NUM_SLOTS; read eligible = !rd_dst_prog_full && occupancy>0.
REQ-026 ARB with no eligible request SHALL stay in ARB; one eligible -> grant it; both eligible -> grant the direction opposite last_grant (round-robin).
REQ-027 ARB->ISSUE on grant, latching txn_write and txn_addr = BASE_ADDR + ptr*BURST_BYTES (wr_ptr for writes, rd_ptr for reads).
REQ-028 ISSUE SHALL assert txn_start for exactly one cycle, then go to WAIT; txn_addr/txn_write SHALL remain stable from ISSUE until leaving WAIT.
REQ-029 WAIT: txn_done=1 && txn_error=0 -> UPDATE; txn_done=1 && txn_error=1 -> ERROR, set err_sticky, no pointer/occupancy change.
REQ-030 WAIT cycle counter reaching TIMEOUT_CYC without txn_done -> ERROR, set timeout.
REQ-031 UPDATE: write increments wr_ptr and occupancy; read increments rd_ptr, decrements occupancy; pointer at NUM_SLOTS-1 wraps to 0; update last_grant; -> ARB.
REQ-032 ERROR: txn_start held 0; clear_err -> IDLE, clearing err_sticky and timeout; pointers and occupancy preserved.
REQ-033 txn_done outside WAIT SHALL be ignored.
REQ-034 occupancy SHALL never exceed NUM_SLOTS nor underflow 0.

Reset
REQ-035 srst SHALL force IDLE, txn_start=0, txn_write=0, txn_addr=BASE_ADDR, occupancy=0, wr_ptr=rd_ptr=0, busy=0, err_sticky=0, timeout=0, last_grant=read (first contested grant is write), WAIT counter 0, including mid-transaction.

Structure
REQ-036 Package axi4_burst_sched_pkg SHALL hold the state enum, the BURST_BYTES computation and direction constants.
REQ-037 Round-robin choice SHALL be sub-module axi4_burst_rr_arb (two requesters, last_grant input, grant outputs).

Verification
REQ-038 Reset then enable, wr_src_prog_empty=0, rd_dst_prog_full=1, txn_done 5 cycles after each start -> 16 writes at 0x00,0x20,...,0x1E0, occupancy 16, then no further starts.
REQ-039 Full buffer, rd_dst_prog_full=0, writes eligible -> grants alternate W/R; write addresses continue 0x000 after wrap, read addresses from 0x000.
REQ-040 txn_done with txn_error=1 on write -> ERROR, err_sticky=1, occupancy unchanged; clear_err -> IDLE, flags 0.
REQ-041 txn_done withheld 1024 cycles -> timeout=1, ERROR, no txn_start until clear_err.
REQ-042 srst asserted in WAIT -> next cycle all outputs at reset values; later txn_done ignored, occupancy stays 0.
REQ-043 enable dropped during WAIT -> burst completes, UPDATE applied, FSM returns IDLE, busy=0.

Source files
------------

// File: rtl/axi4_burst_sched_pkg.sv
// -----------------------------------------------------------------------------
// axi4_burst_sched_pkg
// Shared definitions for the AXI4 burst scheduler:
//   - state_e      : scheduler FSM states
//   - DIR_READ/WRITE : encoding of a transfer direction (also used for last_grant)
//   - burst_bytes() : bytes covered by one burst of BURST_LEN beats
// -----------------------------------------------------------------------------
package axi4_burst_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // Size in bytes of one burst-sized slot of the circular buffer.
  function automatic int burst_bytes(input int burst_len, input int data_width);
    return (burst_len * data_width) / 8;
  endfunction

endpackage

// File: rtl/axi4_burst_sched_if.sv
// -----------------------------------------------------------------------------
// axi4_burst_sched_if
// Command/completion handshake between the burst scheduler and an AXI master
// controller.
//   txn_start : one-cycle pulse starting a burst      (scheduler -> controller)
//   txn_write : 1 = write burst, 0 = read burst       (scheduler -> controller)
//   txn_addr  : burst start address                   (scheduler -> controller)
//   txn_done  : completion pulse                      (controller -> scheduler)
//   txn_error : error flag, valid with txn_done       (controller -> scheduler)
// -----------------------------------------------------------------------------
interface axi4_burst_sched_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  txn_start;
  logic                  txn_write;
  logic [ADDR_WIDTH-1:0] txn_addr;
  logic                  txn_done;
  logic                  txn_error;

  modport master (
    output txn_start,
    output txn_write,
    output txn_addr,
    input  txn_done,
    input  txn_error
  );

  modport slave (
    input  txn_start,
    input  txn_write,
    input  txn_addr,
    output txn_done,
    output txn_error
  );

endinterface

// File: rtl/axi4_burst_rr_arb.sv
// -----------------------------------------------------------------------------
// axi4_burst_rr_arb
// Two-requester round-robin choice between a write and a read burst.
//   req_wr / req_rd : direction is eligible this cycle
//   last_grant      : direction of the most recently completed burst
//   gnt_wr / gnt_rd : one-hot (or zero) grant, combinational
// When both request, the direction opposite last_grant wins.
// -----------------------------------------------------------------------------
module axi4_burst_rr_arb
  import axi4_burst_sched_pkg::*;
(
  input  logic req_wr,
  input  logic req_rd,
  input  logic last_grant,
  output logic gnt_wr,
  output logic gnt_rd
);

  // Grant selection: single requester wins outright, contention alternates.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (req_wr && req_rd) begin
      if (last_grant == DIR_READ) begin
        gnt_wr = 1'b1;
      end else begin
        gnt_rd = 1'b1;
      end
    end else if (req_wr) begin
      gnt_wr = 1'b1;
    end else if (req_rd) begin
      gnt_rd = 1'b1;
    end else begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
    end
  end

endmodule

// File: rtl/axi4_burst_sched.sv
// -----------------------------------------------------------------------------
// axi4_burst_sched
// Schedules write bursts (source FIFO -> memory) and read bursts
// (memory -> destination FIFO) over a circular buffer of NUM_SLOTS burst-sized
// slots starting at BASE_ADDR.
// Ports:
//   clk, srst          : clock, synchronous active-high reset
//   enable             : scheduling permitted (does not abort an in-flight burst)
//   clear_err          : pulse leaving the ERROR state
//   wr_src_prog_empty  : source FIFO holds less than one burst
//   rd_dst_prog_full   : destination FIFO cannot accept one burst
//   bus                : command/completion handshake to the AXI controller
//   occupancy          : number of filled slots
//   busy               : FSM not in IDLE
//   err_sticky/timeout : latched response error / WAIT timeout
// All outputs are registered.
// -----------------------------------------------------------------------------
module axi4_burst_sched
  import axi4_burst_sched_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  BURST_LEN   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                  NUM_SLOTS   = 16,
  parameter int                  TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         enable,
  input  logic                         clear_err,
  input  logic                         wr_src_prog_empty,
  input  logic                         rd_dst_prog_full,
  axi4_burst_sched_if.master           bus,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy,
  output logic                         busy,
  output logic                         err_sticky,
  output logic                         timeout
);

  localparam int OCC_W       = $clog2(NUM_SLOTS + 1);
  localparam int PTR_W       = $clog2(NUM_SLOTS);
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int BURST_BYTES = burst_bytes(BURST_LEN, DATA_WIDTH);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_SLOTS);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SLOTS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    txn_start_q, txn_start_d;
  logic                    txn_write_q, txn_write_d;
  logic [ADDR_WIDTH-1:0]   txn_addr_q, txn_addr_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    to_q, to_d;

  logic req_wr_s, req_rd_s, gnt_wr_s, gnt_rd_s;

  assign req_wr_s = !wr_src_prog_empty && (occ_q < OCC_FULL);
  assign req_rd_s = !rd_dst_prog_full && (occ_q != {OCC_W{1'b0}});

  axi4_burst_rr_arb u_arb (
    .req_wr     (req_wr_s),
    .req_rd     (req_rd_s),
    .last_grant (last_grant_q),
    .gnt_wr     (gnt_wr_s),
    .gnt_rd     (gnt_rd_s)
  );

  // Slot index to byte address within the circular region.
  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [PTR_W-1:0] ptr);
    return BASE_ADDR + (ADDR_WIDTH'(ptr) * ADDR_WIDTH'(BURST_BYTES));
  endfunction

  // Next-state and datapath update for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    txn_write_d  = txn_write_q;
    txn_addr_d   = txn_addr_q;
    err_d        = err_q;
    to_d         = to_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARB: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (gnt_wr_s) begin
          state_d     = ST_ISSUE;
          txn_write_d = DIR_WRITE;
          txn_addr_d  = slot_addr(wr_ptr_q);
        end else if (gnt_rd_s) begin
          state_d     = ST_ISSUE;
          txn_write_d = DIR_READ;
          txn_addr_d  = slot_addr(rd_ptr_q);
        end else begin
          state_d = ST_ARB;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = {CNT_W{1'b0}};
      end

      ST_WAIT: begin
        if (bus.txn_done) begin
          if (bus.txn_error) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_UPDATE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // TIMEOUT_CYC WAIT cycles elapsed with no completion.
          state_d = ST_ERROR;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_UPDATE: begin
        // Saturating occupancy guards keep the count inside [0, NUM_SLOTS].
        if (txn_write_q == DIR_WRITE) begin
          wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_ONE;
          if (occ_q < OCC_FULL) begin
            occ_d = occ_q + OCC_ONE;
          end else begin
            occ_d = occ_q;
          end
        end else begin
          rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_ONE;
          if (occ_q != {OCC_W{1'b0}}) begin
            occ_d = occ_q - OCC_ONE;
          end else begin
            occ_d = occ_q;
          end
        end
        last_grant_d = txn_write_q;
        state_d      = ST_ARB;
      end

      ST_ERROR: begin
        if (clear_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          to_d    = 1'b0;
        end else begin
          state_d = ST_ERROR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    txn_start_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      occ_q        <= {OCC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      last_grant_q <= DIR_READ;
      txn_start_q  <= 1'b0;
      txn_write_q  <= 1'b0;
      txn_addr_q   <= BASE_ADDR;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      txn_start_q  <= txn_start_d;
      txn_write_q  <= txn_write_d;
      txn_addr_q   <= txn_addr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      to_q         <= to_d;
    end
  end

  assign bus.txn_start = txn_start_q;
  assign bus.txn_write = txn_write_q;
  assign bus.txn_addr  = txn_addr_q;
  assign occupancy     = occ_q;
  assign busy          = busy_q;
  assign err_sticky    = err_q;
  assign timeout       = to_q;

endmodule

// File: tb/tb_axi4_burst_sched.sv
// -----------------------------------------------------------------------------
// tb_axi4_burst_sched
// Self-checking bench: each scenario pushes the bursts it expects onto a
// scoreboard queue; the controller-side responder pops and compares on every
// txn_start. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi4_burst_sched;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       srst;
  logic       enable;
  logic       clear_err;
  logic       wr_src_prog_empty;
  logic       rd_dst_prog_full;
  logic [4:0] occupancy;
  logic       busy;
  logic       err_sticky;
  logic       timeout;

  int vectors    = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  axi4_burst_sched_if #(.ADDR_WIDTH(32)) bus ();

  axi4_burst_sched dut (
    .clk               (clk),
    .srst              (srst),
    .enable            (enable),
    .clear_err         (clear_err),
    .wr_src_prog_empty (wr_src_prog_empty),
    .rd_dst_prog_full  (rd_dst_prog_full),
    .bus               (bus),
    .occupancy         (occupancy),
    .busy              (busy),
    .err_sticky        (err_sticky),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  // Wait for one burst start, check it against the scoreboard, then complete it.
  task automatic serve_one(input int delay, input bit err, input bit withhold, input bit drop_en);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.txn_start === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL start_wait: no txn_start within 300 cycles, expected one");
      return;
    end
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_start: txn_start with addr %h, scoreboard empty", bus.txn_addr);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (bus.txn_write !== e.wr || bus.txn_addr !== e.addr) begin
      miscompares++;
      $display("FAIL burst_cmd: got write=%b addr=%h, expected write=%b addr=%h",
               bus.txn_write, bus.txn_addr, e.wr, e.addr);
    end
    @(negedge clk);
    vectors++;
    if (bus.txn_start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_pulse: txn_start=%b one cycle later, expected 0", bus.txn_start);
    end
    if (withhold) return;
    repeat (delay - 1) @(negedge clk);
    vectors++;
    if (bus.txn_addr !== e.addr || bus.txn_write !== e.wr) begin
      miscompares++;
      $display("FAIL cmd_stable: got write=%b addr=%h, expected write=%b addr=%h",
               bus.txn_write, bus.txn_addr, e.wr, e.addr);
    end
    bus.txn_done  = 1'b1;
    bus.txn_error = err;
    if (drop_en) enable = 1'b0;
    @(negedge clk);
    bus.txn_done  = 1'b0;
    bus.txn_error = 1'b0;
  endtask

  // No burst may start for n cycles.
  task automatic expect_quiet(input int n, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.txn_start !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL %s: txn_start seen, expected none for %0d cycles", name, n);
    end
  endtask

  task automatic check_status(input string name, input logic [4:0] occ, input logic b,
                              input logic es, input logic to);
    vectors++;
    if (occupancy !== occ || busy !== b || err_sticky !== es || timeout !== to) begin
      miscompares++;
      $display("FAIL %s: got occ=%0d busy=%b err=%b to=%b, expected occ=%0d busy=%b err=%b to=%b",
               name, occupancy, busy, err_sticky, timeout, occ, b, es, to);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (bus.txn_start !== 1'b0 || bus.txn_write !== 1'b0 || bus.txn_addr !== 32'h0 ||
        occupancy !== 5'd0 || busy !== 1'b0 || err_sticky !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got start=%b write=%b addr=%h occ=%0d busy=%b err=%b to=%b, expected all zero",
               name, bus.txn_start, bus.txn_write, bus.txn_addr, occupancy, busy, err_sticky, timeout);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");
  endtask

  // Writes only: fill all 16 slots, then the scheduler must stall in ARB.
  task automatic test_fill();
    wr_src_prog_empty = 1'b0;
    rd_dst_prog_full  = 1'b1;
    enable            = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back('{wr: 1'b1, addr: 32'(i * 32)});
    for (int i = 0; i < 16; i++) serve_one(5, 1'b0, 1'b0, 1'b0);
    expect_quiet(40, "fill_no_more");
    check_status("fill_full", 5'd16, 1'b1, 1'b0, 1'b0);
  endtask

  // Full buffer then reads allowed: read first, then strict W/R alternation.
  task automatic test_alternate();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: 32'(i * 32)});
      exp_q.push_back('{wr: 1'b1, addr: 32'(i * 32)});
    end
    rd_dst_prog_full = 1'b0;
    for (int i = 0; i < 5; i++) serve_one(5, 1'b0, 1'b0, 1'b0);
    serve_one(5, 1'b0, 1'b0, 1'b1);   // enable dropped while in WAIT
    repeat (4) @(negedge clk);
    check_status("enable_drop_idle", 5'd16, 1'b0, 1'b0, 1'b0);
    expect_quiet(10, "idle_quiet");
  endtask

  // Response error on a write: ERROR, err_sticky, occupancy untouched.
  task automatic test_error();
    rd_dst_prog_full  = 1'b0;
    wr_src_prog_empty = 1'b1;
    enable            = 1'b1;
    exp_q.push_back('{wr: 1'b0, addr: 32'h60});
    serve_one(5, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_status("read_only", 5'd15, 1'b0, 1'b0, 1'b0);
    rd_dst_prog_full  = 1'b1;
    wr_src_prog_empty = 1'b0;
    enable            = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 32'h60});
    serve_one(5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_status("err_latched", 5'd15, 1'b1, 1'b1, 1'b0);
    expect_quiet(30, "err_no_start");
    enable    = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check_status("err_cleared", 5'd15, 1'b0, 1'b0, 1'b0);
  endtask

  // Completion withheld: timeout after TIMEOUT_CYC WAIT cycles.
  task automatic test_timeout();
    int c;
    enable = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 32'h60});
    serve_one(5, 1'b0, 1'b1, 1'b0);
    c = 1;
    while (timeout !== 1'b1 && c < 1200) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (c < 1024 || c > 1027) begin
      miscompares++;
      $display("FAIL timeout_latency: %0d cycles after start, expected 1024..1027", c);
    end
    check_status("timeout_latched", 5'd15, 1'b1, 1'b0, 1'b1);
    expect_quiet(30, "timeout_no_start");
    enable    = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check_status("timeout_cleared", 5'd15, 1'b0, 1'b0, 1'b0);
  endtask

  // srst in WAIT: immediate reset values, late completion ignored.
  task automatic test_srst_mid();
    enable = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 32'h60});
    serve_one(5, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    srst   = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    srst = 1'b0;
    check_reset_outputs("srst_mid_wait");
    bus.txn_done = 1'b1;
    @(negedge clk);
    bus.txn_done = 1'b0;
    repeat (4) @(negedge clk);
    check_status("late_done_ignored", 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // From empty with both sides open: W, then contested grants alternate.
  task automatic test_back_to_back();
    wr_src_prog_empty = 1'b0;
    rd_dst_prog_full  = 1'b0;
    enable            = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 32'h00});
    exp_q.push_back('{wr: 1'b0, addr: 32'h00});
    exp_q.push_back('{wr: 1'b1, addr: 32'h20});
    serve_one(3, 1'b0, 1'b0, 1'b0);
    serve_one(3, 1'b0, 1'b0, 1'b0);
    serve_one(3, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_status("b2b_end", 5'd1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d bursts left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    srst              = 1'b1;
    enable            = 1'b0;
    clear_err         = 1'b0;
    wr_src_prog_empty = 1'b1;
    rd_dst_prog_full  = 1'b1;
    bus.txn_done      = 1'b0;
    bus.txn_error     = 1'b0;
    test_reset();
    test_fill();
    test_alternate();
    test_error();
    test_timeout();
    test_srst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
